// File: rtl/prbs_checker_pkg.sv
// Shared types, default feedback masks and the prediction helper for the PRBS checker.
package prbs_checker_pkg;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} prbs_state_e;

   // Default masks for x^4+x^3+1, x^7+x^6+1 and x^15+x^14+1
   localparam logic [3:0]  TAPS_W4  = 4'b1100;
   localparam logic [6:0]  TAPS_W7  = 7'b110_0000;
   localparam logic [14:0] TAPS_W15 = 15'b110_0000_0000_0000;

   localparam int MAX_W = 32;

   function automatic logic prbs_pred(input logic [MAX_W-1:0] hist, input logic [MAX_W-1:0] taps);
      return ^(hist & taps);
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle of the PRBS checker; bit_cnt exists only with PRBS_CHK_BITCNT_EN.
interface prbs_checker_if #(parameter int ERR_W = 16);

   logic             enable;
   logic             rx_valid;
   logic             rx_bit;
   logic             err_clr;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
   logic [31:0]      bit_cnt;

   modport master (output enable, rx_valid, rx_bit, err_clr,
                   input  locked, err_pulse, err_cnt, bit_cnt);
   modport slave  (input  enable, rx_valid, rx_bit, err_clr,
                   output locked, err_pulse, err_cnt, bit_cnt);
`else
   modport master (output enable, rx_valid, rx_bit, err_clr,
                   input  locked, err_pulse, err_cnt);
   modport slave  (input  enable, rx_valid, rx_bit, err_clr,
                   output locked, err_pulse, err_cnt);
`endif

endinterface

// File: rtl/prbs_checker_err_window.sv
// Error-window tracker: counts errors over WIN checked bits and flags loss of lock at LOSS_THRESH.
module prbs_err_window #(
   parameter int WIN         = 32,
   parameter int LOSS_THRESH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic step,
   input  logic err,
   output logic loss_of_lock
);

   localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int EW = $clog2(LOSS_THRESH + 1);
   localparam logic [PW-1:0] POS_LAST = PW'(WIN - 1);
   localparam logic [EW-1:0] ERR_LAST = EW'(LOSS_THRESH - 1);

   logic [PW-1:0] win_pos;
   logic [EW-1:0] win_err;

   assign loss_of_lock = step & err & (win_err == ERR_LAST);

   // An error on the last bit of a window is checked for loss, then discarded with the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_pos <= '0;
         win_err <= '0;
      end else if (clear || loss_of_lock) begin
         win_pos <= '0;
         win_err <= '0;
      end else if (step) begin
         if (win_pos == POS_LAST) begin
            win_pos <= '0;
            win_err <= '0;
         end else begin
            win_pos <= win_pos + 1'b1;
            if (err) win_err <= win_err + 1'b1;
         end
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection and error counting.
// Optional checked-bit counter enabled by defining PRBS_CHK_BITCNT_EN.
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] TAPS        = TAPS_W4,
   parameter int               LOCK_CNT    = 8,
   parameter int               WIN         = 32,
   parameter int               LOSS_THRESH = 4,
   parameter int               ERR_W       = 16
) (
   input logic           clk,
   input logic           rst_n,
   prbs_checker_if.slave bus
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [FW-1:0] FILL_FULL  = FW'(WIDTH);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);

   prbs_state_e      state, state_nxt;
   logic [WIDTH-1:0] hist, hist_nxt;
   logic [FW-1:0]    fill_cnt, fill_nxt;
   logic [MW-1:0]    match_cnt, match_nxt;
   logic [ERR_W-1:0] err_cnt;
   logic             err_pulse;
   logic             accept, checking, pred, mismatch, loss;

   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   assign accept   = bus.enable & bus.rx_valid;
   assign checking = accept && (state == LOCKED);
   assign pred     = prbs_pred(MAX_W'(hist), MAX_W'(TAPS));
   assign mismatch = checking && (bus.rx_bit != pred);

   prbs_err_window #(.WIN(WIN), .LOSS_THRESH(LOSS_THRESH)) u_err_window (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (state != LOCKED),
      .step         (checking),
      .err          (mismatch),
      .loss_of_lock (loss)
   );

   // SEARCH shifts in received bits; LOCKED free-runs the local LFSR
   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill_cnt;
      match_nxt = match_cnt;
      if (accept) begin
         case (state)
            SEARCH: begin
               hist_nxt = {hist[WIDTH-2:0], bus.rx_bit};
               if (fill_cnt != FILL_FULL) begin
                  fill_nxt = fill_cnt + 1'b1;
               end else if ((hist == '0) || (bus.rx_bit != pred)) begin
                  match_nxt = '0;
               end else if (match_cnt == MATCH_LAST) begin
                  match_nxt = '0;
                  state_nxt = LOCKED;
               end else begin
                  match_nxt = match_cnt + 1'b1;
               end
            end
            LOCKED: begin
               hist_nxt = {hist[WIDTH-2:0], pred};
               if (loss) begin
                  state_nxt = SEARCH;
                  hist_nxt  = '0;
                  fill_nxt  = '0;
                  match_nxt = '0;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEARCH;
         hist      <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         fill_cnt  <= fill_nxt;
         match_cnt <= match_nxt;
      end
   end

   // A clear wins over a coincident error, but the pulse still reports it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt   <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= mismatch;
         if (bus.err_clr)   err_cnt <= '0;
         else if (mismatch) err_cnt <= sat_inc_err(err_cnt);
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   logic [31:0] bit_cnt;

   function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          bit_cnt <= '0;
      else if (bus.err_clr) bit_cnt <= '0;
      else if (checking)   bit_cnt <= sat_inc_bits(bit_cnt);
   end

   assign bus.bit_cnt = bit_cnt;
`endif

   assign bus.locked    = (state == LOCKED);
   assign bus.err_pulse = err_pulse;
   assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: vector table, directed corner sequences and a random run.
module tb_prbs_checker;
   import prbs_checker_pkg::*;

   localparam int WIDTH       = 4;
   localparam int LOCK_CNT    = 8;
   localparam int WIN         = 32;
   localparam int LOSS_THRESH = 4;
   localparam int ERR_W       = 16;
   localparam int ERR_MAX     = (1 << ERR_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prbs_checker_if #(.ERR_W(ERR_W)) bus ();

   prbs_checker #(
      .WIDTH(WIDTH), .TAPS(4'b1100), .LOCK_CNT(LOCK_CNT),
      .WIN(WIN), .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   bit prbs15 [15] = '{1,1,1,1,0,0,0,1,0,0,1,1,0,1,0};
   int sp;

   int checks   = 0;
   int failures = 0;

   // Reference: the stream obeys s[n] = s[n-3] ^ s[n-4]; q keeps recent bits, newest last
   bit          q[$];
   bit          m_locked;
   bit          m_pulse;
   int          m_run;
   int          m_err;
   int          m_win_pos;
   int          m_win_err;
   int unsigned m_bits;

   typedef struct {
      bit en;
      bit vld;
      bit rx;
      bit exp_locked;
      bit exp_pulse;
      int exp_err;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_locked  = 0;
      m_pulse   = 0;
      m_run     = 0;
      m_err     = 0;
      m_win_pos = 0;
      m_win_err = 0;
      m_bits    = 0;
   endtask

   task automatic model_step(input bit acc, input bit rx, input bit clr);
      bit p, e, nz;
      e = 1'b0;
      if (acc && m_locked) begin
         p = q[q.size()-3] ^ q[q.size()-4];
         e = (rx != p);
         q.push_back(p);
         if (m_bits != 32'hFFFF_FFFF) m_bits++;
         if (e) m_win_err++;
         if (e && m_win_err == LOSS_THRESH) begin
            m_locked = 0;
            m_run    = 0;
            q.delete();
         end else begin
            m_win_pos++;
            if (m_win_pos == WIN) begin
               m_win_pos = 0;
               m_win_err = 0;
            end
         end
      end else if (acc) begin
         if (q.size() >= WIDTH) begin
            p  = q[q.size()-3] ^ q[q.size()-4];
            nz = q[q.size()-1] | q[q.size()-2] | q[q.size()-3] | q[q.size()-4];
            m_run = (nz && rx == p) ? m_run + 1 : 0;
            if (m_run == LOCK_CNT) begin
               m_locked  = 1;
               m_run     = 0;
               m_win_pos = 0;
               m_win_err = 0;
            end
         end
         q.push_back(rx);
      end
      if (q.size() > 8) void'(q.pop_front());
      m_pulse = e;
      if (clr) begin
         m_err  = 0;
         m_bits = 0;
      end else if (e && m_err != ERR_MAX) begin
         m_err++;
      end
   endtask

   task automatic cycle(input bit en, input bit vld, input bit rx, input bit clr);
      bus.enable   = en;
      bus.rx_valid = vld;
      bus.rx_bit   = rx;
      bus.err_clr  = clr;
      @(posedge clk);
      model_step(en & vld, rx, clr);
      #1;
      chk("locked", bus.locked, m_locked);
      chk("err_pulse", bus.err_pulse, m_pulse);
      chk("err_cnt", bus.err_cnt, m_err);
`ifdef PRBS_CHK_BITCNT_EN
      chk("bit_cnt", bus.bit_cnt, m_bits);
`endif
   endtask

   task automatic send(input bit inv, input bit clr);
      bit rx;
      rx = prbs15[sp] ^ inv;
      sp = (sp + 1) % 15;
      cycle(1'b1, 1'b1, rx, clr);
   endtask

   task automatic do_reset();
      bus.enable   = 0;
      bus.rx_valid = 0;
      bus.rx_bit   = 0;
      bus.err_clr  = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #12;
      rst_n = 1'b1;
   endtask

   initial begin
      bit en, vld, inv, clr, rx;

      for (int i = 0; i < 12; i++) tbl[i] = '{1, 1, prbs15[i], (i == 11), 0, 0};
      tbl[12] = '{0, 1, 1, 1, 0, 0};
      tbl[13] = '{1, 0, 1, 1, 0, 0};
      tbl[14] = '{1, 1, prbs15[12], 1, 0, 0};

      bus.enable = 0; bus.rx_valid = 0; bus.rx_bit = 0; bus.err_clr = 0;
      model_reset();
      #12;
      chk("rst_locked", bus.locked, 0);
      chk("rst_err_pulse", bus.err_pulse, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
`ifdef PRBS_CHK_BITCNT_EN
      chk("rst_bit_cnt", bus.bit_cnt, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Lock after the 12th bit; pauses keep the sequence position
      for (int i = 0; i < 15; i++) begin
         cycle(tbl[i].en, tbl[i].vld, tbl[i].rx, 1'b0);
         chk($sformatf("tbl%0d_locked", i), bus.locked, tbl[i].exp_locked);
         chk($sformatf("tbl%0d_pulse", i), bus.err_pulse, tbl[i].exp_pulse);
         chk($sformatf("tbl%0d_err", i), bus.err_cnt, tbl[i].exp_err);
      end
      sp = 13;

      for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
      chk("clean100_locked", bus.locked, 1);
      chk("clean100_err", bus.err_cnt, 0);

      send(1'b1, 1'b0);
      chk("single_pulse", bus.err_pulse, 1);
      chk("single_err", bus.err_cnt, 1);
      chk("single_locked", bus.locked, 1);

      // Asynchronous reset between edges while pulse, count and lock are all set
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_locked", bus.locked, 0);
      chk("async_err_cnt", bus.err_cnt, 0);
      chk("async_err_pulse", bus.err_pulse, 0);
      model_reset();
      #4;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) send(1'b0, 1'b0);
      chk("relock_locked", bus.locked, 1);
      send(1'b0, 1'b0);
      chk("pulse_one_clk", bus.err_pulse, 0);

      for (int i = 0; i < 7; i++) send(i % 2 == 0, 1'b0);
      chk("loss_locked", bus.locked, 0);
      chk("loss_err_cnt", bus.err_cnt, 4);
      for (int i = 0; i < 11; i++) send(1'b0, 1'b0);
      chk("relock11_locked", bus.locked, 0);
      send(1'b0, 1'b0);
      chk("relock12_locked", bus.locked, 1);
      chk("relock_err_cnt", bus.err_cnt, 4);

      send(1'b1, 1'b1);
      chk("clr_err_pulse", bus.err_pulse, 1);
      chk("clr_err_cnt", bus.err_cnt, 0);

      do_reset();
      for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("zeros_locked", bus.locked, 0);
      chk("zeros_err_cnt", bus.err_cnt, 0);

`ifdef PRBS_CHK_BITCNT_EN
      do_reset();
      for (int i = 0; i < 12; i++) send(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
      chk("bitcnt_20", bus.bit_cnt, 20);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("bitcnt_hold", bus.bit_cnt, 20);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("bitcnt_clr", bus.bit_cnt, 0);
`endif

      // Random traffic with gaps, bit errors, slips, zero bursts and clears
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(9) != 0);
         vld = ($urandom_range(9) != 0);
         inv = ($urandom_range(24) == 0);
         clr = ($urandom_range(99) == 0);
         if ($urandom_range(399) == 0) sp = (sp + 1) % 15;
         rx = (i >= 1500 && i < 1560) ? 1'b0 : (prbs15[sp] ^ inv);
         if (en && vld) sp = (sp + 1) % 15;
         cycle(en, vld, rx, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
